// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: producer classes,
// stall cause codes, default latencies and the cause priority helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_LONG = 2'd2,
    CLS_RSV  = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_RAW  = 2'd1,
    CAUSE_LONG = 2'd2,
    CAUSE_BR   = 2'd3
  } cause_e;

  localparam int DEF_NREGS   = 32;
  localparam int DEF_RAW     = 5;
  localparam int DEF_ALU_LAT = 1;
  localparam int DEF_LU_LAT  = 2;
  localparam int DEF_LAT_W   = 3;
  localparam int DEF_PERF_W  = 32;

  // Long-busy/WAW outranks a plain RAW, which outranks a branch-only RAW.
  function automatic cause_e sel_cause(input logic stall,
                                       input logic long_c,
                                       input logic raw_c);
    cause_e c;
    if (!stall)      c = CAUSE_NONE;
    else if (long_c) c = CAUSE_LONG;
    else if (raw_c)  c = CAUSE_RAW;
    else             c = CAUSE_BR;
    return c;
  endfunction

endpackage

// File: rtl/hazard_reg_slot.sv
// One scoreboard entry: a forwarding countdown plus a long-unit busy flag
// for a single architectural register.
module hazard_reg_slot
  import hazard_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hold,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_set_busy,
  input  logic             i_clr_busy,
  output logic [LAT_W-1:0] o_cnt,
  output logic             o_busy
);

  logic [LAT_W-1:0] r_cnt;
  logic             r_busy;

  // A reload from a fresh issue takes precedence over the ageing decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      if (i_load)
        r_cnt <= i_load_val;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - LAT_W'(1);
    end
  end

  // A new long producer for this register wins over a same-cycle writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else if (!i_hold) begin
      if (i_set_busy)
        r_busy <= 1'b1;
      else if (i_clr_busy)
        r_busy <= 1'b0;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_busy = r_busy;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register readiness scoreboard beside ID: decides stall for the
// instruction in ID, tracks the single long-latency unit, counts stalls.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS   = DEF_NREGS,
  parameter int RAW     = DEF_RAW,
  parameter int ALU_LAT = DEF_ALU_LAT,
  parameter int LU_LAT  = DEF_LU_LAT,
  parameter int LAT_W   = DEF_LAT_W,
  parameter int PERF_W  = DEF_PERF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [RAW-1:0]    id_rs1,
  input  logic [RAW-1:0]    id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_branch,
  input  logic              id_wb,
  input  logic [RAW-1:0]    id_rd,
  input  logic [1:0]        id_class,
  input  logic              long_done,
  input  logic [RAW-1:0]    long_rd,
  output logic              stall,
  output logic [1:0]        stall_cause,
  output logic [PERF_W-1:0] stall_cycles
);

  logic [LAT_W-1:0]  w_cnt  [NREGS];
  logic              w_busy [NREGS];
  logic              r_long_active;
  logic [PERF_W-1:0] r_stall_cycles;

  logic             w_issue;
  logic             w_is_long;
  logic [LAT_W-1:0] w_load_val;

  // x0 is hardwired zero and never has a pending producer.
  assign w_cnt[0]  = '0;
  assign w_busy[0] = 1'b0;

  assign w_is_long  = (id_class == CLS_LONG);
  assign w_load_val = (id_class == CLS_LOAD) ? LAT_W'(LU_LAT) : LAT_W'(ALU_LAT);

  for (genvar g = 1; g < NREGS; g++) begin : g_slot
    logic w_hit_rd;
    logic w_hit_long;

    assign w_hit_rd   = w_issue & (id_rd == RAW'(g));
    assign w_hit_long = long_done & (long_rd == RAW'(g));

    hazard_reg_slot #(.LAT_W(LAT_W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_hold     (hold),
      .i_load     (w_hit_rd & ~w_is_long),
      .i_load_val (w_load_val),
      .i_set_busy (w_hit_rd & w_is_long),
      .i_clr_busy (w_hit_long),
      .o_cnt      (w_cnt[g]),
      .o_busy     (w_busy[g])
    );
  end

  logic             w_use1, w_use2;
  logic [LAT_W-1:0] w_cnt1, w_cnt2;
  logic             w_raw_ex, w_raw_br, w_src_busy, w_waw, w_lbusy;
  logic             w_stall;

  assign w_use1 = id_use_rs1 & (id_rs1 != '0);
  assign w_use2 = id_use_rs2 & (id_rs2 != '0);
  assign w_cnt1 = w_cnt[id_rs1];
  assign w_cnt2 = w_cnt[id_rs2];

  // A count of 1 is already forwardable to EX but not yet to the ID compare.
  assign w_raw_ex   = (w_use1 & (w_cnt1 > LAT_W'(1))) | (w_use2 & (w_cnt2 > LAT_W'(1)));
  assign w_raw_br   = id_branch & ((w_use1 & (w_cnt1 != '0)) | (w_use2 & (w_cnt2 != '0)));
  assign w_src_busy = (w_use1 & w_busy[id_rs1]) | (w_use2 & w_busy[id_rs2]);
  assign w_waw      = id_wb & w_busy[id_rd];
  assign w_lbusy    = w_is_long & r_long_active & ~long_done;

  assign w_stall = id_valid & (w_raw_ex | w_raw_br | w_src_busy | w_waw | w_lbusy);
  assign w_issue = id_valid & id_wb & (id_rd != '0) & ~w_stall & ~flush & ~hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_long_active <= 1'b0;
    end else if (!hold) begin
      if (w_issue & w_is_long)
        r_long_active <= 1'b1;
      else if (long_done)
        r_long_active <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall & ~hold & ~(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign stall        = w_stall;
  assign stall_cause  = sel_cause(w_stall, w_src_busy | w_waw | w_lbusy, w_raw_ex);
  assign stall_cycles = r_stall_cycles;

endmodule
